instruction_encoder: RTL and testbench
======================================

# instruction_encoder

Pipelined RV32I instruction encoder: the packing counterpart of the decode-side immediate extraction. It accepts decoded fields (format, opcode, register indices, funct fields, 32-bit immediate) over a valid/ready handshake and emits the canonical 32-bit instruction word, flagging immediates the format cannot represent. It sits in the self-test / program-generation path, feeding instruction-memory write logic and bench stimulus generators.

## Interface
- COUNT_W, 16, width of the emitted-word counter
- Clk_i  input  1  rising-edge clock
- Rst_i  input  1  reset; one clock, synchronous and active-high
- Valid_i  input  1  field set on inputs is valid
- Ready_o  output  1  encoder accepts a field set this cycle
- Format_i  input  3  instruction format code (package enum)
- Opcode_i  input  7  opcode[6:0]
- Rd_i, Rs1_i, Rs2_i  input  5 each  register indices
- Funct3_i  input  3  funct3
- Funct7_i  input  7  funct7 (R format only)
- Immediate_i  input  32  sign-extended byte-offset immediate, as the decoder produces it
- Valid_o  output  1  Instruction_o/Error_o valid
- Ready_i  input  1  downstream accepts the word
- Instruction_o  output  32  encoded word
- Error_o  output  1  word is bad: invalid format or immediate out of range
- Count_o  output  COUNT_W  words handed off since reset

## Operation
- Stage S1 registers the accepted field set. Stage S2 registers the packed word and error.
- S1→S2 move when S1 is valid and (S2 is empty or an output handshake occurs this cycle).
- Ready_o = !Rst_i && (!S1_valid || move). Throughput is 1 word/clock.
- Packing, RV32I standard:
  - R: f7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Fields not used by a format are ignored.
- Format codes 6 and 7 are invalid: word = 32'h0, Error_o = 1. This check is always present.
- Count_o increments on each Valid_o && Ready_i and wraps modulo 2^COUNT_W.

## Timing
- Reset values:
  - Valid_o = 0, Instruction_o = 0, Error_o = 0, Count_o = 0.
  - Ready_o = 0 while Rst_i is high, and 1 in the first cycle after reset.
- Latency: a field set accepted at edge k shows on Valid_o/Instruction_o after edge k+1.
- Stall: while Valid_o && !Ready_i, Instruction_o and Error_o stay stable. S1 still fills once, then Ready_o = 0.
- Both stages full with a simultaneous output handshake and input acceptance: S2 takes S1, S1 takes the new input, and no bubble is inserted.
- Reset mid-operation: both stages are flushed and in-flight words are dropped, never emitted. Count_o clears.
- Count_o wrap: all-ones plus one handshake gives 0.

## Configuration
- IMM_RANGE_CHECK_EN defined: Error_o is also set when the immediate does not fit its format:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0] = 1.
  - J: imm[31:20] not all equal, or imm[0] = 1.
  - U: imm[11:0] ≠ 0.
  - R: no check.
  - The word is still packed from the truncated bits.
- Undefined: no range logic. Only invalid formats set Error_o, and out-of-range bits are silently truncated.

## Structure
- Shared package riscv_format_pkg holds:
  - format enum: R=0, I=1, S=2, B=3, U=4, J=5
  - RV32I opcode constants
  - a struct bundling the S1 field set
- The decode side uses the same package.
- One sub-module, imm_packer: combinational format+fields → word + range error, instantiated between S1 and S2.

## Test plan
- addi x1,x0,5 (I, op 0x13, rd 1, rs1 0, f3 0, imm 5) → 0x00500093, Error_o 0, two clocks after acceptance.
- beq x1,x2,-4 (B, op 0x63, rs1 1, rs2 2, imm 0xFFFFFFFC) → 0xFE208EE3.
- jal x1,2048 (J, op 0x6F, rd 1, imm 0x800) → 0x001000EF.
- I, op 0x13, rd 1, imm 2048 → 0x80000093 with Error_o 1 when IMM_RANGE_CHECK_EN is defined, Error_o 0 when undefined. Format_i 7 → 0x00000000 with Error_o 1 in both builds.
- Back-to-back stream of 3 words with Ready_i low for 4 cycles:
  - Ready_o drops after 2 accepts.
  - Instruction_o holds.
  - Order is preserved.
  - Count_o = 3 after drain.
- Rst_i high one cycle with both stages full → next cycle Valid_o 0, Count_o 0, Ready_o 1, and no stale word ever appears.

Source files
------------

// File: rtl/riscv_format_pkg.sv
// rtl/riscv_format_pkg.sv - RV32I format codes, opcode constants and field-set struct shared by encode and decode
package riscv_format_pkg;

  // Instruction format codes; 6 and 7 are reserved and rejected by the encoder
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } format_e;

  // RV32I base opcodes
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  // Decoded field set; format kept as raw bits so reserved codes survive to the packer
  typedef struct packed {
    logic [2:0]  format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } field_set_t;

  // True when bits [31:msb] of a value are all equal, i.e. it survives sign truncation at msb
  function automatic logic sext_fits(input logic [31:0] value, input int msb);
    logic all_ones;
    logic all_zeros;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= msb) begin
        all_ones  = all_ones & value[i];
        all_zeros = all_zeros & ~value[i];
      end
    end
    return all_ones | all_zeros;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - combinational RV32I word packing with format/immediate error (IMM_RANGE_CHECK_EN adds range checks)
module imm_packer
  import riscv_format_pkg::*;
(
  input  field_set_t  fields,
  output logic [31:0] word,
  output logic        error
);

  logic [31:0] imm;
  logic        format_bad;
  logic        range_bad;

  assign imm = fields.imm;

  // Scatter fields into the canonical bit positions for each format
  always_comb begin
    word       = 32'h0;
    format_bad = 1'b0;
    case (fields.format)
      FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_I: word = {imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      FMT_S: word = {imm[11:5], fields.rs2, fields.rs1, fields.funct3, imm[4:0], fields.opcode};
      FMT_B: word = {imm[12], imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                     imm[4:1], imm[11], fields.opcode};
      FMT_U: word = {imm[31:12], fields.rd, fields.opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, fields.opcode};
      default: begin
        word       = 32'h0;
        format_bad = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates whose dropped bits carry information; the word above is still packed from truncated bits
  always_comb begin
    range_bad = 1'b0;
    case (fields.format)
      FMT_I, FMT_S: range_bad = !sext_fits(imm, 11);
      FMT_B:        range_bad = !sext_fits(imm, 12) || imm[0];
      FMT_J:        range_bad = !sext_fits(imm, 20) || imm[0];
      FMT_U:        range_bad = (imm[11:0] != 12'h0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  assign error = format_bad | range_bad;

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - two-stage RV32I encoder with valid/ready handshake and word counter (IMM_RANGE_CHECK_EN)
module instruction_encoder
  import riscv_format_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               Clk_i,
  input  logic               Rst_i,
  input  logic               Valid_i,
  output logic               Ready_o,
  input  logic [2:0]         Format_i,
  input  logic [6:0]         Opcode_i,
  input  logic [4:0]         Rd_i,
  input  logic [4:0]         Rs1_i,
  input  logic [4:0]         Rs2_i,
  input  logic [2:0]         Funct3_i,
  input  logic [6:0]         Funct7_i,
  input  logic [31:0]        Immediate_i,
  output logic               Valid_o,
  input  logic               Ready_i,
  output logic [31:0]        Instruction_o,
  output logic               Error_o,
  output logic [COUNT_W-1:0] Count_o
);

  logic        s1_valid;
  field_set_t  s1_fields;
  field_set_t  in_fields;
  logic [31:0] packed_word;
  logic        packed_error;
  logic        out_hs;
  logic        move;
  logic        accept;

  assign in_fields = '{format: Format_i, opcode: Opcode_i, rd: Rd_i, rs1: Rs1_i, rs2: Rs2_i,
                       funct3: Funct3_i, funct7: Funct7_i, imm: Immediate_i};

  // S2 is the output register itself, so a handshake frees it in the same cycle S1 refills it
  assign out_hs  = Valid_o && Ready_i;
  assign move    = s1_valid && (!Valid_o || out_hs);
  assign Ready_o = !Rst_i && (!s1_valid || move);
  assign accept  = Valid_i && Ready_o;

  imm_packer u_imm_packer (
    .fields (s1_fields),
    .word   (packed_word),
    .error  (packed_error)
  );

  // S1: capture the accepted field set, empty it when it advances without a replacement
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      s1_valid  <= 1'b0;
      s1_fields <= '0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_fields <= in_fields;
    end else if (move) begin
      s1_valid  <= 1'b0;
    end
  end

  // S2: hold the packed word until downstream takes it
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      Valid_o       <= 1'b0;
      Instruction_o <= 32'h0;
      Error_o       <= 1'b0;
    end else if (move) begin
      Valid_o       <= 1'b1;
      Instruction_o <= packed_word;
      Error_o       <= packed_error;
    end else if (out_hs) begin
      Valid_o       <= 1'b0;
    end
  end

  // Count words handed off, wrapping naturally at the counter width
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      Count_o <= '0;
    end else if (out_hs) begin
      Count_o <= Count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// tb/tb_instruction_encoder.sv - scoreboard bench for instruction_encoder against an arithmetic reference model
module tb_instruction_encoder;

  localparam int CW = 4;

  logic          Clk_i = 1'b0;
  logic          Rst_i;
  logic          Valid_i;
  logic          Ready_o;
  logic [2:0]    Format_i;
  logic [6:0]    Opcode_i;
  logic [4:0]    Rd_i, Rs1_i, Rs2_i;
  logic [2:0]    Funct3_i;
  logic [6:0]    Funct7_i;
  logic [31:0]   Immediate_i;
  logic          Valid_o;
  logic          Ready_i;
  logic [31:0]   Instruction_o;
  logic          Error_o;
  logic [CW-1:0] Count_o;

  instruction_encoder #(.COUNT_W(CW)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .Format_i(Format_i), .Opcode_i(Opcode_i), .Rd_i(Rd_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i),
    .Funct3_i(Funct3_i), .Funct7_i(Funct7_i), .Immediate_i(Immediate_i),
    .Valid_o(Valid_o), .Ready_i(Ready_i), .Instruction_o(Instruction_o),
    .Error_o(Error_o), .Count_o(Count_o)
  );

  always #5 Clk_i = ~Clk_i;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } stim_t;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic rand_sink = 1'b0;
  logic force_ready = 1'b1;
  logic stall_prev = 1'b0;
  logic [31:0] held_word;
  logic held_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: place each immediate slice by division/modulo, range by signed bounds
  function automatic exp_t model(input stim_t s);
    exp_t r;
    longint unsigned u, w;
    longint sv;
    logic e;
    u = {32'h0, s.imm};
    sv = longint'($signed(s.imm));
    w = 0;
    e = 1'b0;
    case (s.fmt)
      3'd0: w = s.op + s.rd * 2**7 + s.f3 * 2**12 + s.rs1 * 2**15 + s.rs2 * 2**20 + s.f7 * 2**25;
      3'd1: begin
        w = s.op + s.rd * 2**7 + s.f3 * 2**12 + s.rs1 * 2**15 + (u % 4096) * 2**20;
`ifdef IMM_RANGE_CHECK_EN
        e = (sv < -2048) || (sv > 2047);
`endif
      end
      3'd2: begin
        w = s.op + (u % 32) * 2**7 + s.f3 * 2**12 + s.rs1 * 2**15 + s.rs2 * 2**20
            + ((u / 32) % 128) * 2**25;
`ifdef IMM_RANGE_CHECK_EN
        e = (sv < -2048) || (sv > 2047);
`endif
      end
      3'd3: begin
        w = s.op + ((u / 2048) % 2) * 2**7 + ((u / 2) % 16) * 2**8 + s.f3 * 2**12
            + s.rs1 * 2**15 + s.rs2 * 2**20 + ((u / 32) % 64) * 2**25 + ((u / 4096) % 2) * 2**31;
`ifdef IMM_RANGE_CHECK_EN
        e = (sv < -4096) || (sv > 4095) || (u % 2 == 1);
`endif
      end
      3'd4: begin
        w = s.op + s.rd * 2**7 + (u / 4096) * 4096;
`ifdef IMM_RANGE_CHECK_EN
        e = (u % 4096) != 0;
`endif
      end
      3'd5: begin
        w = s.op + s.rd * 2**7 + ((u / 4096) % 256) * 2**12 + ((u / 2048) % 2) * 2**20
            + ((u / 2) % 1024) * 2**21 + ((u / 2**20) % 2) * 2**31;
`ifdef IMM_RANGE_CHECK_EN
        e = (sv < -(2**20)) || (sv > 2**20 - 1) || (u % 2 == 1);
`endif
      end
      default: begin
        w = 0;
        e = 1'b1;
      end
    endcase
    r.word = w[31:0];
    r.err  = e;
    return r;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.fmt = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
    s.op  = 7'($urandom);
    s.rd  = 5'($urandom);
    s.rs1 = 5'($urandom);
    s.rs2 = 5'($urandom);
    s.f3  = 3'($urandom);
    s.f7  = 7'($urandom);
    case ($urandom_range(0, 3))
      0: s.imm = $urandom;
      1: s.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: s.imm = (32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000) & 32'hFFFF_FFFE;
      default: s.imm = $urandom & 32'hFFFF_F000;
    endcase
    return s;
  endfunction

  function automatic stim_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    stim_t s;
    s.fmt = fmt; s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
    s.f3 = 3'd0; s.f7 = 7'd0; s.imm = imm;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    Format_i = s.fmt; Opcode_i = s.op; Rd_i = s.rd; Rs1_i = s.rs1; Rs2_i = s.rs2;
    Funct3_i = s.f3; Funct7_i = s.f7; Immediate_i = s.imm;
  endtask

  // Hold a field set until accepted; expected value is the given constant or the model
  task automatic send(input stim_t s, input logic use_exp, input logic [31:0] ew, input logic ee);
    logic done;
    exp_t x;
    done = 1'b0;
    apply(s);
    Valid_i = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge Clk_i);
      if (Ready_o) begin
        if (use_exp) begin
          x.word = ew;
          x.err  = ee;
        end else begin
          x = model(s);
        end
        sb.push_back(x);
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge Clk_i);
    #1;
    Valid_i = 1'b0;
  endtask

  task automatic step();
    @(posedge Clk_i);
    #1;
  endtask

  // Downstream ready, random or forced, updated just after each rising edge
  initial begin
    Ready_i = 1'b1;
    forever begin
      @(posedge Clk_i);
      #2;
      Ready_i = rand_sink ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  // Monitor: pop and compare on every output handshake, check stall stability and counter
  initial begin
    exp_t x;
    forever begin
      @(negedge Clk_i);
      if (Rst_i) begin
        sb.delete();
        exp_cnt = 0;
        stall_prev = 1'b0;
      end else begin
        chk("count", 32'(Count_o), 32'(exp_cnt % (2**CW)));
        if (stall_prev) begin
          chk("stall_valid", 32'(Valid_o), 32'd1);
          chk("stall_word", Instruction_o, held_word);
          chk("stall_err", 32'(Error_o), 32'(held_err));
        end
        if (Valid_o && Ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", Instruction_o, 32'hDEAD_BEEF);
          end else begin
            x = sb.pop_front();
            chk("word", Instruction_o, x.word);
            chk("error", 32'(Error_o), 32'(x.err));
          end
          exp_cnt++;
        end
        stall_prev = Valid_o && !Ready_i;
        held_word  = Instruction_o;
        held_err   = Error_o;
      end
    end
  end

  initial begin
    stim_t items[3];
    int accepts;
    exp_t x;
    Rst_i = 1'b1;
    Valid_i = 1'b0;
    apply(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0));
    step();
    step();
    @(negedge Clk_i);
    chk("reset_ready", 32'(Ready_o), 32'd0);
    chk("reset_valid", 32'(Valid_o), 32'd0);
    chk("reset_word", Instruction_o, 32'd0);
    chk("reset_err", 32'(Error_o), 32'd0);
    chk("reset_count", 32'(Count_o), 32'd0);
    step();
    Rst_i = 1'b0;
    @(negedge Clk_i);
    chk("ready_after_reset", 32'(Ready_o), 32'd1);
    step();

    // addi x1,x0,5 with latency check
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5), 1'b1, 32'h0050_0093, 1'b0);
    @(negedge Clk_i);
    chk("latency_not_early", 32'(Valid_o), 32'd0);
    @(negedge Clk_i);
    chk("latency_valid", 32'(Valid_o), 32'd1);
    chk("latency_word", Instruction_o, 32'h0050_0093);
    step();

    send(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC), 1'b1, 32'hFE20_8EE3, 1'b0);
    send(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 32'h0000_0800), 1'b1, 32'h0010_00EF, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1, 32'h8000_0093, 1'b1);
`else
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd2048), 1'b1, 32'h8000_0093, 1'b0);
`endif
    send(mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 32'd5), 1'b1, 32'h0000_0000, 1'b1);
    for (int c = 0; c < 20 && sb.size() != 0; c++) step();
    chk("directed_drain", 32'(sb.size()), 32'd0);

    // Reset with both stages full: in-flight words must never appear
    force_ready = 1'b0;
    step();
    send(rand_stim(), 1'b0, 32'd0, 1'b0);
    send(rand_stim(), 1'b0, 32'd0, 1'b0);
    Rst_i = 1'b1;
    @(negedge Clk_i);
    chk("rst_ready_low", 32'(Ready_o), 32'd0);
    step();
    Rst_i = 1'b0;
    force_ready = 1'b1;
    @(negedge Clk_i);
    chk("flush_valid", 32'(Valid_o), 32'd0);
    chk("flush_count", 32'(Count_o), 32'd0);
    chk("flush_ready", 32'(Ready_o), 32'd1);
    for (int c = 0; c < 5; c++) step();

    // Three back-to-back words against four cycles of backpressure
    force_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) items[i] = rand_stim();
    accepts = 0;
    apply(items[0]);
    Valid_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk_i);
      if (Ready_o && accepts < 3) begin
        x = model(items[accepts]);
        sb.push_back(x);
        accepts++;
      end
      step();
      if (accepts < 3) apply(items[accepts]);
      else Valid_i = 1'b0;
    end
    @(negedge Clk_i);
    chk("stall_accepts", 32'(accepts), 32'd2);
    chk("stall_ready_low", 32'(Ready_o), 32'd0);
    force_ready = 1'b1;
    step();
    for (int c = 0; c < 20 && accepts < 3; c++) begin
      @(negedge Clk_i);
      if (Ready_o) begin
        x = model(items[accepts]);
        sb.push_back(x);
        accepts++;
      end
      step();
    end
    Valid_i = 1'b0;
    for (int c = 0; c < 6; c++) step();
    chk("stall_all_accepted", 32'(accepts), 32'd3);
    @(negedge Clk_i);
    chk("stall_count_after_drain", 32'(Count_o), 32'd3);
    chk("stall_drain", 32'(sb.size()), 32'd0);
    step();

    // Randomized traffic with random backpressure and idle gaps; counter wraps repeatedly
    rand_sink = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(rand_stim(), 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) step();
    end
    rand_sink = 1'b0;
    force_ready = 1'b1;
    for (int c = 0; c < 100 && sb.size() != 0; c++) step();
    chk("final_drain", 32'(sb.size()), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
